arena_seeder: RTL and testbench
===============================

ARENA_SEEDER -- requirements
Module: arena_seeder

Interface
REQ-001 SHALL have parameter ARENA_WIDTH, default 48: cells per row, range 2..256.
REQ-002 SHALL have parameter ARENA_HEIGHT, default 10: rows, range 1..256.
REQ-003 SHALL have parameter DENSITY_BITS, default 4: random bits per cell, range 1..8.
REQ-004 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-005 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1: begin fill; sampled only while ready=1.
REQ-007 SHALL have port abort, input, 1: stop fill immediately and return to IDLE.
REQ-008 SHALL have port ready, output, 1: high in IDLE.
REQ-009 SHALL have port seed, input, 32: LFSR seed, captured on accepted start.
REQ-010 SHALL have port density, input, DENSITY_BITS+1: alive threshold, captured on accepted start.
REQ-011 SHALL have port mirror, input, 1: horizontal-symmetry request, captured on accepted start.
REQ-012 SHALL have port arena_row_select, output, 8: row address.
REQ-013 SHALL have port arena_columns_new, output, ARENA_WIDTH: row data, bit c = column c.
REQ-014 SHALL have port arena_columns_write, output, 1: one-cycle row write strobe.

Function
REQ-015 SHALL implement states IDLE, FILL, WRITE: IDLE->FILL on start&ready; FILL->WRITE after last cell of row; WRITE->FILL if more rows, else ->IDLE.
REQ-016 SHALL use 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1; seed 0 replaced by 32'h0000_0001.
REQ-017 SHALL in FILL produce one cell per cycle: advance LFSR DENSITY_BITS steps in one cycle, r = low DENSITY_BITS bits after advance, cell alive iff r < captured density.
REQ-018 SHALL fill columns 0,1,2,... in order into a row buffer; density=0 gives all dead, density=2^DENSITY_BITS gives all alive.
REQ-019 SHALL assert arena_columns_write for exactly the WRITE cycle, with row buffer on arena_columns_new and current row on arena_row_select; rows written 0..ARENA_HEIGHT-1.
REQ-020 SHALL take ARENA_WIDTH FILL cycles + 1 WRITE cycle per row; whole fill = ARENA_HEIGHT*(ARENA_WIDTH+1) cycles from start accept to ready high.
REQ-021 SHALL drop ready the cycle after start accepted and raise it the cycle after final WRITE.
REQ-022 SHALL ignore start while ready=0; changes to seed/density/mirror mid-fill do not affect the fill.
REQ-023 SHALL on abort (any state but IDLE) go to IDLE next cycle with no further writes; abort coincident with WRITE suppresses that write; abort has priority over start.
REQ-024 SHALL keep arena_columns_write=0 and outputs stable outside WRITE.

Reset
REQ-025 SHALL on reset_n=0 asynchronously force IDLE, ready=1, arena_columns_write=0, arena_row_select=0, arena_columns_new=0, LFSR=32'h0000_0001, counters 0.
REQ-026 SHALL on reset mid-fill abandon the fill; written rows stay as written.

Configuration
REQ-027 SHALL with macro ARENA_SEEDER_MIRROR_EN defined honour mirror=1: generate only ceil(ARENA_WIDTH/2) cells per row (columns 0..ceil(W/2)-1), copy column c to ARENA_WIDTH-1-c; per-row cost ceil(W/2)+1 cycles.
REQ-028 SHALL without ARENA_SEEDER_MIRROR_EN ignore mirror, behaving as mirror=0; port remains present.

Verification
REQ-029 SHALL cover W=48,H=10,DB=4, seed=32'hcafebabe, density=0 -> 10 writes, rows 0..9, all data 0, ready high 490 cycles after start accept.
REQ-030 SHALL cover density=16 -> all 10 rows 48'hFFFF_FFFF_FFFF; density=8 -> rows match reference LFSR model bit-exactly.
REQ-031 SHALL cover seed=0 -> output identical to seed=32'h0000_0001.
REQ-032 SHALL cover abort asserted in 3rd row's WRITE cycle -> exactly 2 writes, ready=1 next cycle; reset_n pulse mid-fill -> immediate ready=1, no writes.
REQ-033 SHALL cover start held high through fill -> one fill only, then second fill starts the cycle ready returns.
REQ-034 SHALL cover, with ARENA_SEEDER_MIRROR_EN, mirror=1, W=48 -> every row palindromic, 10*25 cycles total; without macro -> same as mirror=0.

Source files
------------

// File: rtl/arena_seeder.sv
// arena_seeder: fills an ARENA_WIDTH x ARENA_HEIGHT cell arena row by row from
// a 32-bit Galois LFSR. Each cell consumes DENSITY_BITS LFSR steps and is alive
// when the resulting low bits fall below the captured density threshold.
// Optional feature macro: ARENA_SEEDER_MIRROR_EN enables horizontally
// symmetric rows (only the left half is generated, the right half mirrors it).
module arena_seeder #(
  parameter int ARENA_WIDTH  = 48,
  parameter int ARENA_HEIGHT = 10,
  parameter int DENSITY_BITS = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    abort,
  output logic                    ready,
  input  logic [31:0]             seed,
  input  logic [DENSITY_BITS:0]   density,
  input  logic                    mirror,
  output logic [7:0]              arena_row_select,
  output logic [ARENA_WIDTH-1:0]  arena_columns_new,
  output logic                    arena_columns_write
);

  localparam int             CW        = $clog2(ARENA_WIDTH);
  localparam logic [CW-1:0]  COL_LAST  = CW'(ARENA_WIDTH - 1);
  localparam logic [CW-1:0]  HALF_LAST = CW'((ARENA_WIDTH + 1) / 2 - 1);
  localparam logic [7:0]     ROW_LAST  = 8'(ARENA_HEIGHT - 1);
  // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
  localparam logic [31:0]    POLY      = 32'h8020_0003;

`ifdef ARENA_SEEDER_MIRROR_EN
  localparam bit MIRROR_EN = 1'b1;
`else
  localparam bit MIRROR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE} state_t;

  state_t                 state_q, state_d;
  logic [31:0]            lfsr_q, lfsr_adv;
  logic [DENSITY_BITS:0]  density_q;
  logic                   mirror_q;
  logic [CW-1:0]          col_q;
  logic [7:0]             row_q;
  logic [ARENA_WIDTH-1:0] row_buf_q, row_fill;
  logic                   alive, last_cell;

  assign ready               = (state_q == S_IDLE);
  // An abort landing on the WRITE cycle must kill that very write.
  assign arena_columns_write = (state_q == S_WRITE) && !abort;

  // LFSR advance by DENSITY_BITS steps, cell decision and row-buffer update.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch can be inferred.
    lfsr_adv = lfsr_q;
    for (int i = 0; i < DENSITY_BITS; i++) begin
      lfsr_adv = lfsr_adv[0] ? ((lfsr_adv >> 1) ^ POLY) : (lfsr_adv >> 1);
    end
    alive     = ({1'b0, lfsr_adv[DENSITY_BITS-1:0]} < density_q);
    last_cell = (col_q == (mirror_q ? HALF_LAST : COL_LAST));
    row_fill  = row_buf_q;
    row_fill[col_q] = alive;
    if (mirror_q) row_fill[COL_LAST - col_q] = alive;
  end

  // Next-state logic; abort wins over everything, including a pending start.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start && !abort) state_d = S_FILL;
      S_FILL:  if (abort) state_d = S_IDLE;
               else if (last_cell) state_d = S_WRITE;
      S_WRITE: if (abort || row_q == ROW_LAST) state_d = S_IDLE;
               else state_d = S_FILL;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Datapath: parameter capture on start, per-cell fill, output row latch on WRITE entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q            <= 32'h0000_0001;
      density_q         <= '0;
      mirror_q          <= 1'b0;
      col_q             <= '0;
      row_q             <= '0;
      row_buf_q         <= '0;
      arena_row_select  <= '0;
      arena_columns_new <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (state_d == S_FILL) begin
            lfsr_q    <= (seed == 32'd0) ? 32'h0000_0001 : seed;
            density_q <= density;
            mirror_q  <= mirror & MIRROR_EN;
            col_q     <= '0;
            row_q     <= '0;
          end
        end
        S_FILL: begin
          // Every column is rewritten each row, so the buffer needs no clearing between rows.
          lfsr_q    <= lfsr_adv;
          row_buf_q <= row_fill;
          col_q     <= col_q + 1'b1;
          if (state_d == S_WRITE) begin
            col_q             <= '0;
            arena_columns_new <= row_fill;
            arena_row_select  <= row_q;
          end
        end
        S_WRITE: row_q <= row_q + 8'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_arena_seeder.sv
// Self-checking bench for arena_seeder: table of fill vectors compared against
// an arithmetic reference model, plus hand sequences for abort, reset and
// held-start corner cases.
module tb_arena_seeder;

  localparam int W  = 48;
  localparam int H  = 10;
  localparam int DB = 4;

`ifdef ARENA_SEEDER_MIRROR_EN
  localparam bit MIR_ON = 1'b1;
`else
  localparam bit MIR_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start, abort, mirror;
  logic [31:0]   seed;
  logic [DB:0]   density;
  logic          ready;
  logic [7:0]    arena_row_select;
  logic [W-1:0]  arena_columns_new;
  logic          arena_columns_write;

  always #5 clk = ~clk;

  arena_seeder #(.ARENA_WIDTH(W), .ARENA_HEIGHT(H), .DENSITY_BITS(DB)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .start               (start),
    .abort               (abort),
    .ready               (ready),
    .seed                (seed),
    .density             (density),
    .mirror              (mirror),
    .arena_row_select    (arena_row_select),
    .arena_columns_new   (arena_columns_new),
    .arena_columns_write (arena_columns_write)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] exp_rows [H];

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    logic [31:0] feedback;
    feedback = (s % 2 == 1) ? 32'h8020_0003 : 32'd0;
    return (s / 2) ^ feedback;
  endfunction

  function automatic int cells_per_row(input logic mir);
    return (mir && MIR_ON) ? (W + 1) / 2 : W;
  endfunction

  task automatic build_model(input logic [31:0] sd, input logic [DB:0] dn, input logic mir);
    logic [31:0] s;
    int          r;
    bit          a;
    s = (sd == 0) ? 32'd1 : sd;
    for (int row = 0; row < H; row++) begin
      exp_rows[row] = '0;
      for (int c = 0; c < cells_per_row(mir); c++) begin
        for (int k = 0; k < DB; k++) s = lfsr_next(s);
        r = int'(s % (32'd1 << DB));
        a = (r < int'(dn));
        exp_rows[row][c] = a;
        if (mir && MIR_ON) exp_rows[row][W-1-c] = a;
      end
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] seed;
    logic [DB:0] dens;
    logic        mir;
    int          exp_cyc;
    int          kind;      // 0: model only, 1: all dead, 2: all alive
  } vec_t;

  localparam int NV = 10;
  vec_t tbl [NV];

  logic [W-1:0] got_data [$];
  logic [7:0]   got_sel  [$];

  task automatic run_vec(input int idx, input vec_t v);
    logic [W-1:0] prev;
    int           cnt, stab;
    bit           done;
    build_model(v.seed, v.dens, v.mir);
    got_data.delete();
    got_sel.delete();
    @(posedge clk); #1;
    start = 1'b1; seed = v.seed; density = v.dens; mirror = v.mir;
    @(posedge clk); #1;
    start = 1'b0;
    // scramble captured-on-start inputs: the fill must not notice
    seed = $urandom; density = 5'($urandom_range(0, 16)); mirror = ~v.mir;
    check($sformatf("v%0d_ready_drop", idx), ready, 0);
    cnt = 0; stab = 0; done = 0;
    prev = arena_columns_new;
    while (!done && cnt < v.exp_cyc + 50) begin
      @(posedge clk); cnt++; #1;
      if (arena_columns_write) begin
        got_data.push_back(arena_columns_new);
        got_sel.push_back(arena_row_select);
      end else if (arena_columns_new !== prev) begin
        stab++;
      end
      prev = arena_columns_new;
      if (ready) done = 1;
    end
    check($sformatf("v%0d_cycles", idx), 64'(cnt), 64'(v.exp_cyc));
    check($sformatf("v%0d_nwrites", idx), 64'(got_data.size()), 64'(H));
    check($sformatf("v%0d_stable", idx), 64'(stab), 0);
    for (int r = 0; r < H; r++) begin
      if (r < got_data.size()) begin
        check($sformatf("v%0d_sel%0d", idx, r), 64'(got_sel[r]), 64'(r));
        check($sformatf("v%0d_row%0d", idx, r), 64'(got_data[r]), 64'(exp_rows[r]));
        if (v.kind == 1) check($sformatf("v%0d_dead%0d", idx, r), 64'(got_data[r]), 0);
        if (v.kind == 2) check($sformatf("v%0d_alive%0d", idx, r), 64'(got_data[r]), 64'(48'hFFFF_FFFF_FFFF));
        if (v.mir && MIR_ON) begin
          for (int c = 0; c < W / 2; c++)
            check($sformatf("v%0d_pal%0d_%0d", idx, r, c), 64'(got_data[r][c]), 64'(got_data[r][W-1-c]));
        end
      end
    end
  endtask

  int nwr, cnt, bad;
  bit aborted, seen;

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; mirror = 1'b0;
    seed = 32'd0; density = '0;

    // reset state
    #2;
    check("rst_ready", ready, 1);
    check("rst_write", arena_columns_write, 0);
    check("rst_sel", arena_row_select, 0);
    check("rst_cols", 64'(arena_columns_new), 0);
    #10 reset_n = 1'b1;

    tbl[0] = '{32'hcafebabe, 5'd0,  1'b0, H * (W + 1), 1};
    tbl[1] = '{32'hcafebabe, 5'd16, 1'b0, H * (W + 1), 2};
    tbl[2] = '{32'hcafebabe, 5'd8,  1'b0, H * (W + 1), 0};
    tbl[3] = '{32'h00000000, 5'd8,  1'b0, H * (W + 1), 0};
    tbl[4] = '{32'h00000001, 5'd8,  1'b0, H * (W + 1), 0};
    tbl[5] = '{32'hcafebabe, 5'd8,  1'b1, MIR_ON ? H * 25 : H * (W + 1), 0};
    for (int i = 6; i < NV; i++) begin
      tbl[i].seed    = $urandom;
      tbl[i].dens    = 5'($urandom_range(0, 16));
      tbl[i].mir     = 1'($urandom_range(0, 1));
      tbl[i].exp_cyc = H * (cells_per_row(tbl[i].mir) + 1);
      tbl[i].kind    = 0;
    end
    for (int i = 0; i < NV; i++) run_vec(i, tbl[i]);

    // abort during the third row's WRITE cycle
    @(posedge clk); #1;
    start = 1'b1; seed = 32'h1234_5678; density = 5'd16; mirror = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    nwr = 0; aborted = 0; cnt = 0;
    while (!aborted && cnt < 600) begin
      @(posedge clk); cnt++; #1;
      if (arena_columns_write) begin
        if (nwr == 2) begin
          abort = 1'b1; aborted = 1; #1;
          if (arena_columns_write) nwr++;
        end else nwr++;
      end
    end
    check("abort_reached", aborted, 1);
    check("abort_cycle", 64'(cnt), 64'(2 * (W + 1) + W));
    @(posedge clk); #1; abort = 1'b0;
    check("abort_ready", ready, 1);
    repeat (60) begin
      @(posedge clk); #1;
      if (arena_columns_write) nwr++;
    end
    check("abort_nwrites", 64'(nwr), 2);

    // reset pulse mid-fill
    @(posedge clk); #1;
    start = 1'b1; seed = 32'h0bad_f00d; density = 5'd8;
    @(posedge clk); #1; start = 1'b0;
    repeat (100) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("rstmid_ready", ready, 1);
    check("rstmid_write", arena_columns_write, 0);
    check("rstmid_sel", arena_row_select, 0);
    reset_n = 1'b1;
    bad = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (arena_columns_write || !ready) bad++;
    end
    check("rstmid_quiet", 64'(bad), 0);

    // start held high through a fill; mid-fill density change ignored
    @(posedge clk); #1;
    start = 1'b1; seed = 32'hcafebabe; density = 5'd16; mirror = 1'b0;
    @(posedge clk); #1;
    density = 5'd0;
    nwr = 0; bad = 0; cnt = 0; seen = 0;
    while (!seen && cnt < 600) begin
      @(posedge clk); cnt++; #1;
      if (arena_columns_write) begin
        nwr++;
        if (arena_columns_new !== {W{1'b1}}) bad++;
      end
      if (ready) seen = 1;
    end
    check("held_cycles", 64'(cnt), 64'(H * (W + 1)));
    check("held_nwrites", 64'(nwr), 64'(H));
    check("held_data", 64'(bad), 0);
    @(posedge clk); #1;
    check("held_restart", ready, 0);
    start = 1'b0;
    seen = 0; cnt = 0;
    while (!seen && cnt < 60) begin
      @(posedge clk); cnt++; #1;
      if (arena_columns_write) seen = 1;
    end
    check("held2_write_seen", seen, 1);
    check("held2_sel", arena_row_select, 0);
    check("held2_data", 64'(arena_columns_new), 0);
    abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    check("held2_abort_ready", ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
